// File: rtl/gf_pkg.sv
// Shared encodings for the GF(2^M) multiply/divide/inverse unit.
package gf_pkg;

    localparam logic [1:0] OP_MUL = 2'd0;
    localparam logic [1:0] OP_INV = 2'd1;
    localparam logic [1:0] OP_DIV = 2'd2;

    localparam logic [8:0] POLY_M8 = 9'h11B;

    typedef enum logic [2:0] {
        IDLE,
        MULT,
        SQR,
        ACC,
        FIN,
        HOLD
    } state_t;

endpackage

// File: rtl/gf2m_mul_serial.sv
// Bit-serial MSB-first GF(2^M) multiplier. The first step runs on the start
// edge, so p is valid (done pulses) exactly M cycles after the start cycle.
module gf2m_mul_serial #(
    parameter int         M    = 8,
    parameter logic [M:0] POLY = 9'h11B
) (
    input  logic         clock,
    input  logic         reset_n,
    input  logic         start,
    input  logic [M-1:0] x,
    input  logic [M-1:0] y,
    output logic         busy,
    output logic         done,
    output logic [M-1:0] p
);

    logic [M-1:0] xr;
    logic [M-1:0] yr;
    logic [M-1:0] acc;
    logic [4:0]   cnt;

    // acc*x^(1) mod POLY, then conditionally add the multiplicand
    function automatic logic [M-1:0] step(input logic [M-1:0] s,
                                          input logic [M-1:0] xv,
                                          input logic         sel);
        logic [M:0] t;
        t = {s, 1'b0};
        if (t[M]) t = t ^ POLY;
        if (sel)  t = t ^ {1'b0, xv};
        return t[M-1:0];
    endfunction

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            xr   <= '0;
            yr   <= '0;
            acc  <= '0;
            cnt  <= '0;
            busy <= 1'b0;
            done <= 1'b0;
        end else begin
            done <= 1'b0;
            if (start) begin
                xr   <= x;
                yr   <= {y[M-2:0], 1'b0};
                acc  <= step('0, x, y[M-1]);
                cnt  <= 5'(M-1);
                busy <= 1'b1;
            end else if (busy) begin
                acc <= step(acc, xr, yr[M-1]);
                yr  <= {yr[M-2:0], 1'b0};
                cnt <= cnt - 5'd1;
                if (cnt == 5'd1) begin
                    busy <= 1'b0;
                    done <= 1'b1;
                end
            end
        end
    end

    assign p = acc;

endmodule

// File: rtl/gf2m_muldivinv_seq.sv
// GF(2^M) multiply / inverse / divide unit with valid/ready handshakes.
// Inverse is b^(2^M-2) by square-and-multiply on one serial multiplier.
module gf2m_muldivinv_seq
    import gf_pkg::*;
#(
    parameter int         M    = 8,
    parameter logic [M:0] POLY = POLY_M8
) (
    input  logic         clock,
    input  logic         reset_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [1:0]   op,
    input  logic [M-1:0] a,
    input  logic [M-1:0] b,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [M-1:0] result,
    output logic         div_zero
);

    state_t       state, state_nxt;
    logic [M-1:0] a_r, b_r, t, r, t_nxt, r_nxt;
    logic [1:0]   op_r;
    logic [4:0]   cnt, cnt_nxt;
    logic         zero, kick;
    logic         accept;

    logic         m_start, m_busy, m_done;
    logic [M-1:0] m_x, m_y, m_p;

    gf2m_mul_serial #(.M(M), .POLY(POLY)) u_mul (
        .clock   (clock),
        .reset_n (reset_n),
        .start   (m_start),
        .x       (m_x),
        .y       (m_y),
        .busy    (m_busy),
        .done    (m_done),
        .p       (m_p)
    );

    assign in_ready  = (state == IDLE);
    assign out_valid = (state == HOLD);
    assign accept    = in_valid && (state == IDLE);

    // Next multiply starts in the same cycle the previous one finishes, so the
    // operand mux looks at the next state and next t/r values.
    always_comb begin
        state_nxt = state;
        t_nxt     = t;
        r_nxt     = r;
        cnt_nxt   = cnt;
        m_start   = kick;
        case (state)
            IDLE: if (in_valid) state_nxt = (op == OP_INV || op == OP_DIV) ? SQR : MULT;
            MULT: if (m_done) begin
                r_nxt     = m_p;
                state_nxt = HOLD;
            end
            SQR: if (m_done) begin
                t_nxt     = m_p;
                state_nxt = ACC;
                m_start   = 1'b1;
            end
            ACC: if (m_done) begin
                r_nxt = m_p;
                if (cnt == 5'(M-1)) begin
                    state_nxt = (op_r == OP_DIV) ? FIN : HOLD;
                    m_start   = (op_r == OP_DIV);
                end else begin
                    cnt_nxt   = cnt + 5'd1;
                    state_nxt = SQR;
                    m_start   = 1'b1;
                end
            end
            FIN: if (m_done) begin
                r_nxt     = m_p;
                state_nxt = HOLD;
            end
            HOLD: if (out_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase

        m_x = a_r;
        m_y = b_r;
        case (state_nxt)
            SQR: begin
                m_x = t_nxt;
                m_y = t_nxt;
            end
            ACC: begin
                m_x = r_nxt;
                m_y = t_nxt;
            end
            FIN: begin
                m_x = a_r;
                m_y = r_nxt;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state    <= IDLE;
            a_r      <= '0;
            b_r      <= '0;
            op_r     <= OP_MUL;
            t        <= '0;
            r        <= '0;
            cnt      <= '0;
            zero     <= 1'b0;
            kick     <= 1'b0;
            result   <= '0;
            div_zero <= 1'b0;
        end else begin
            state <= state_nxt;
            kick  <= accept;
            if (accept) begin
                a_r  <= a;
                b_r  <= b;
                op_r <= op;
                t    <= b;
                r    <= M'(1);
                cnt  <= 5'd1;
                zero <= (op == OP_INV || op == OP_DIV) && (b == '0);
            end else begin
                t   <= t_nxt;
                r   <= r_nxt;
                cnt <= cnt_nxt;
            end
            if (state != HOLD && state_nxt == HOLD) begin
                result   <= zero ? '0 : r_nxt;
                div_zero <= zero;
            end
        end
    end

endmodule

// File: doc/gf2m_muldivinv_seq.md
Name: gf2m_muldivinv_seq

Overview:
- Parametrised, multi-cycle GF(2^M) arithmetic unit that computes multiply, inverse or divide on request.
- Successor to the fixed 8-bit finite-field multiply/divide/inverse block: field width and reduction polynomial are parameters, operation is selected per transaction, and valid/ready handshakes are added.
- Sits between a request source (datapath or CPU-side register block) and a result consumer.
- Inversion is by square-and-multiply (b^(2^M-2)) on one shared bit-serial multiplier.

Parameters:
- M, 8, field width in bits (2..16).
- POLY, 9'h11B, reduction polynomial including the x^M term, width M+1.

Ports:
- clock  in  1  system clock, rising edge.
- reset_n  in  1  asynchronous active-low reset.
- in_valid  in  1  request valid.
- in_ready  out  1  unit can accept a request.
- op  in  2  operation: 0 MUL a*b, 1 INV b^-1, 2 DIV a/b, 3 reserved (treated as MUL).
- a  in  M  first operand / dividend (ignored for INV).
- b  in  M  second operand / divisor.
- out_valid  out  1  result valid.
- out_ready  in  1  consumer accepts result.
- result  out  M  field result.
- div_zero  out  1  qualifies result: op was INV/DIV with b==0.

Behaviour:
- Clock is clock; reset is asynchronous, active-low on reset_n. Reset values: in_ready=1, out_valid=0, result=0, div_zero=0, FSM=IDLE. Reset mid-operation abandons the operation; no result is produced.
- Accept: in_valid & in_ready at a rising edge. a, b and op are registered on that edge. in_ready=1 only in IDLE.
- FSM states: IDLE, MULT (single multiply), SQR, ACC, FIN, HOLD.
- Multiplier: sub-module, MSB-first shift-and-add with reduction by POLY each step. A start pulse leads to product valid exactly M cycles later.
- MUL: IDLE -> MULT (r=a*b) -> HOLD.
- INV/DIV: t=b, r=1. For i=1..M-1: SQR (t=t*t), then ACC (r=r*t).
  - INV then goes to HOLD.
  - DIV goes to FIN (r=a*r), then HOLD.
- Latency, accept edge to out_valid high, is fixed and data-independent:
  - MUL: M+1 cycles.
  - INV: 2(M-1)M+1 cycles.
  - DIV: (2M-1)M+1 cycles.
  - For M=8: 9 / 113 / 121.
- Zero operand: if op is INV/DIV and b==0, the FSM still runs the full latency. result=0 and div_zero=1; otherwise div_zero=0. MUL with a zero operand gives result 0, div_zero=0.
- HOLD: out_valid=1. result and div_zero are stable until out_valid & out_ready.
  - On handshake: out_valid drops and the FSM returns to IDLE (in_ready=1 next cycle).
  - No new request is accepted in the same cycle as the handshake.
- Result is always reduced: width M, value < 2^M.
- out_ready is ignored outside HOLD. in_valid is ignored while in_ready=0.

Decomposition:
- Shared package gf_pkg holds:
  - op encodings OP_MUL=0, OP_INV=1, OP_DIV=2;
  - FSM state enum;
  - default POLY constant for M=8 (9'h11B).
- One sub-module: gf2m_mul_serial (parameters M, POLY; ports clock, reset_n, start, x, y, busy, done, p).

Test Plan:
- M=8, MUL a=0x57 b=0x83 -> result=0xC1, div_zero=0, out_valid exactly 9 cycles after accept.
- INV b=0x53 -> result=0xCA after 113 cycles. INV b=0x02 -> result=0x8D. INV b=0x01 -> 0x01.
- DIV a=0xC1 b=0x83 -> result=0x57 after 121 cycles. DIV a=0x00 b=0x05 -> 0x00, div_zero=0.
- DIV a=0x0B b=0x00 -> result=0x00, div_zero=1, latency still 121. INV b=0x00 -> 0x00, div_zero=1.
- Backpressure: hold out_ready=0 for 20 cycles after out_valid -> result stable, in_ready=0, second request not accepted. Release -> in_ready=1 next cycle.
- Assert reset_n low mid-DIV (cycle 50) -> out_valid=0, in_ready=1 immediately. A following MUL completes correctly. Also run M=4, POLY=5'h13: INV 0x2 -> 0x9.
